// File: rtl/reg_file_bank_if.sv
// Register file bank bus: write port from WB, two read ports toward ID,
// and the sticky decode-check flag.
interface reg_file_bank_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  localparam int NREGS = 2 ** ADDR_W;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREGS-1:0]  wr_onehot;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              dec_err;

  // Pipeline side: drives write/read requests, receives read data and status.
  modport master (
    output wr_en, wr_addr, wr_data, wr_onehot, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, dec_err
  );

  // Register file side.
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_onehot, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, dec_err
  );
endinterface

// File: rtl/reg_file_bank.sv
// Architectural register file: one-hot qualified write port, two combinational
// read ports with same-cycle write bypass, hard-wired zero register, and a
// sticky flag raised when the decoded write vector disagrees with wr_en/wr_addr.
module reg_file_bank #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_file_bank_if.slave bus
);
  localparam int                NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  onehot_exp;
  logic              dec_err_q;
  logic              dec_err_d;

  // Next-state per register: the one-hot vector alone selects the write;
  // the zero register has no real storage and is held at 0.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    if (gi == ZERO_REG) begin : g_zero
      assign regs_d[gi] = '0;
    end else begin : g_store
      assign regs_d[gi] = bus.wr_onehot[gi] ? bus.wr_data : regs_q[gi];
    end
  end

  // Register storage, cleared asynchronously so a write in flight is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Decode check: the vector the decode tree should have produced.
  assign onehot_exp = bus.wr_en ? (NREGS'(1) << bus.wr_addr) : '0;
  assign dec_err_d  = dec_err_q | (bus.wr_onehot != onehot_exp);

  // Sticky decode-error flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_err_q <= 1'b0;
    else        dec_err_q <= dec_err_d;
  end

  assign bus.dec_err = dec_err_q;

  // Read ports: zero register wins over bypass, bypass wins over storage.
  // Bypass is suppressed in reset so the whole file reads 0 while rst_n is low.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = (gi == 0) ? bus.rd_addr1 : bus.rd_addr2;

    // Combinational read mux for this port.
    always_comb begin
      data = regs_q[addr];
      if (addr == ZERO_IDX) begin
        data = '0;
      end else if (rst_n && bus.wr_en && (bus.wr_addr == addr)) begin
        data = bus.wr_data;
      end
    end
  end

  assign bus.rd_data1 = g_rd[0].data;
  assign bus.rd_data2 = g_rd[1].data;
endmodule

// File: tb/tb_reg_file_bank.sv
// Self-checking bench for reg_file_bank: directed scenarios plus randomized
// traffic compared against a behavioural register-array model.
module tb_reg_file_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_bank_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  reg_file_bank #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model: plain array of architectural registers plus sticky error.
  logic [63:0] m_regs [32];
  bit          m_err;

  function automatic logic [63:0] ref_read(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
    return m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_err = 1'b0;
  endtask

  // One clock edge; the model applies the same edge, then we settle 1 ns.
  task automatic clock_cycle();
    logic [31:0] exp_vec;
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 31; i++)
        if (bus.wr_onehot[i]) m_regs[i] = bus.wr_data;
      exp_vec = bus.wr_en ? (32'd1 << bus.wr_addr) : 32'd0;
      if (bus.wr_onehot != exp_vec) m_err = 1'b1;
    end
    #1;
  endtask

  task automatic set_idle();
    bus.wr_en     = 1'b0;
    bus.wr_onehot = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = a;
    bus.wr_data   = d;
    bus.wr_onehot = 32'd1 << a;
    clock_cycle();
    set_idle();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] a;
    for (int k = 0; k < 8; k++) begin
      a = 5'($urandom_range(0, 30));
      do_write(a, {$urandom, $urandom});
    end
    // Write pending when reset arrives; hold it across an edge.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 64'hAAAA_5555_AAAA_5555;
    bus.wr_onehot = 32'd1 << 2;
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    set_idle();
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr1 = 5'(i);
      bus.rd_addr2 = 5'(31 - i);
      #1;
      n_tests++;
      if (bus.rd_data1 !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_rd1 addr=%0d got=%h exp=0", i, bus.rd_data1);
      end
      n_tests++;
      if (bus.rd_data2 !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_rd2 addr=%0d got=%h exp=0", 31 - i, bus.rd_data2);
      end
    end
    n_tests++;
    if (bus.dec_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dec_err got=%b exp=0", bus.dec_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Discarded write must not appear after release.
    bus.rd_addr1 = 5'd2;
    #1;
    n_tests++;
    if (bus.rd_data1 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_discard reg2 got=%h exp=0", bus.rd_data1);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_write();
    logic [63:0] exp;
    do_write(5'd5, 64'hDEAD_BEEF_0000_0001);
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr1 = 5'(i);
      #1;
      exp = (i == 5) ? 64'hDEAD_BEEF_0000_0001 : ref_read(5'(i));
      n_tests++;
      if (bus.rd_data1 !== exp) begin
        n_fail++;
        $display("FAIL write_readback addr=%0d got=%h exp=%h", i, bus.rd_data1, exp);
      end
    end
    $display("[TB] test_write done");
  endtask

  task automatic test_bypass();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h1234;
    bus.wr_onehot = 32'd1 << 7;
    bus.rd_addr1 = 5'd7; bus.rd_addr2 = 5'd7;
    @(negedge clk);
    n_tests++;
    if (bus.rd_data1 !== 64'h1234 || bus.rd_data2 !== 64'h1234) begin
      n_fail++;
      $display("FAIL bypass_same_cycle got=%h/%h exp=%h", bus.rd_data1, bus.rd_data2, 64'h1234);
    end
    clock_cycle();
    set_idle();
    #1;
    n_tests++;
    if (bus.rd_data1 !== 64'h1234 || bus.rd_data2 !== 64'h1234) begin
      n_fail++;
      $display("FAIL bypass_stored got=%h/%h exp=%h", bus.rd_data1, bus.rd_data2, 64'h1234);
    end
    $display("[TB] test_bypass done");
  endtask

  task automatic test_zero_reg();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = '1;
    bus.wr_onehot = 32'd1 << 31;
    bus.rd_addr1 = 5'd31; bus.rd_addr2 = 5'd31;
    @(negedge clk);
    n_tests++;
    if (bus.rd_data1 !== 64'd0 || bus.rd_data2 !== 64'd0) begin
      n_fail++;
      $display("FAIL zero_same_cycle got=%h/%h exp=0", bus.rd_data1, bus.rd_data2);
    end
    clock_cycle();
    set_idle();
    #1;
    n_tests++;
    if (bus.rd_data1 !== 64'd0) begin
      n_fail++;
      $display("FAIL zero_after got=%h exp=0", bus.rd_data1);
    end
    n_tests++;
    if (bus.dec_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_dec_err got=%b exp=0", bus.dec_err);
    end
    $display("[TB] test_zero_reg done");
  endtask

  task automatic test_decode_err();
    logic [63:0] old3;
    old3 = m_regs[3];
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'h0BAD_DEC0_DE00_0004;
    bus.wr_onehot = 32'd1 << 4;
    clock_cycle();
    set_idle();
    bus.rd_addr1 = 5'd4; bus.rd_addr2 = 5'd3;
    #1;
    n_tests++;
    if (bus.rd_data1 !== 64'h0BAD_DEC0_DE00_0004) begin
      n_fail++;
      $display("FAIL decode_reg4 got=%h exp=%h", bus.rd_data1, 64'h0BAD_DEC0_DE00_0004);
    end
    n_tests++;
    if (bus.rd_data2 !== old3) begin
      n_fail++;
      $display("FAIL decode_reg3 got=%h exp=%h", bus.rd_data2, old3);
    end
    for (int k = 0; k < 4; k++) begin
      clock_cycle();
      n_tests++;
      if (bus.dec_err !== 1'b1) begin
        n_fail++;
        $display("FAIL decode_sticky cyc=%0d got=%b exp=1", k, bus.dec_err);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (bus.dec_err !== 1'b0) begin
      n_fail++;
      $display("FAIL decode_clear got=%b exp=0", bus.dec_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("[TB] test_decode_err done");
  endtask

  task automatic test_sweep();
    logic [63:0] exp;
    for (int i = 0; i < 32; i++) do_write(5'(i), 64'(i) * 64'h0101);
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr1 = 5'(i);
      bus.rd_addr2 = 5'(i);
      #1;
      exp = (i == 31) ? 64'd0 : 64'(i) * 64'h0101;
      n_tests++;
      if (bus.rd_data1 !== exp || bus.rd_data2 !== exp) begin
        n_fail++;
        $display("FAIL sweep addr=%0d got=%h/%h exp=%h", i, bus.rd_data1, bus.rd_data2, exp);
      end
    end
    $display("[TB] test_sweep done");
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2;
    logic [4:0]  wa [3];
    logic [4:0]  r1 [3];
    logic [4:0]  r2 [3];
    wa = '{5'd9, 5'd9, 5'd10};
    r1 = '{5'd9, 5'd9, 5'd9};
    r2 = '{5'd10, 5'd10, 5'd10};
    for (int k = 0; k < 3; k++) begin
      bus.wr_en = 1'b1; bus.wr_addr = wa[k]; bus.wr_data = {$urandom, $urandom};
      bus.wr_onehot = 32'd1 << wa[k];
      bus.rd_addr1 = r1[k]; bus.rd_addr2 = r2[k];
      @(negedge clk);
      e1 = ref_read(r1[k]);
      e2 = ref_read(r2[k]);
      n_tests++;
      if (bus.rd_data1 !== e1 || bus.rd_data2 !== e2) begin
        n_fail++;
        $display("FAIL back_to_back step=%0d got=%h/%h exp=%h/%h", k, bus.rd_data1, bus.rd_data2, e1, e2);
      end
      clock_cycle();
    end
    set_idle();
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_random();
    int          r;
    logic [63:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      bus.wr_en   = 1'($urandom_range(0, 1));
      bus.wr_addr = 5'($urandom);
      bus.wr_data = {$urandom, $urandom};
      r = $urandom_range(0, 19);
      if (r == 0)      bus.wr_onehot = 32'($urandom);
      else if (r == 1) bus.wr_onehot = '0;
      else             bus.wr_onehot = bus.wr_en ? (32'd1 << bus.wr_addr) : 32'd0;
      bus.rd_addr1 = ($urandom_range(0, 3) == 0) ? bus.wr_addr : 5'($urandom);
      bus.rd_addr2 = ($urandom_range(0, 3) == 0) ? bus.wr_addr : 5'($urandom);
      @(negedge clk);
      e1 = ref_read(bus.rd_addr1);
      e2 = ref_read(bus.rd_addr2);
      n_tests++;
      if (bus.rd_data1 !== e1) begin
        n_fail++;
        $display("FAIL random_rd1 it=%0d addr=%0d got=%h exp=%h", n, bus.rd_addr1, bus.rd_data1, e1);
      end
      n_tests++;
      if (bus.rd_data2 !== e2) begin
        n_fail++;
        $display("FAIL random_rd2 it=%0d addr=%0d got=%h exp=%h", n, bus.rd_addr2, bus.rd_data2, e2);
      end
      clock_cycle();
      n_tests++;
      if (bus.dec_err !== m_err) begin
        n_fail++;
        $display("FAIL random_dec_err it=%0d got=%b exp=%b", n, bus.dec_err, m_err);
      end
    end
    set_idle();
    $display("[TB] test_random done");
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_onehot = '0;
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    model_clear();
    #12;
    rst_n = 1'b1;
    #1;
    test_reset();
    test_write();
    test_bypass();
    test_zero_reg();
    test_decode_err();
    test_sweep();
    test_back_to_back();
    pulse_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
